// File: rtl/ysyx_22050710_axi4_burst_master.sv
// AXI4-full burst master front end.
// Converts a core-side request/response handshake into one INCR read burst
// (1..256 beats) or one single-beat write, and returns every read beat and
// every write response on a single response port with error flags.
module ysyx_22050710_axi4_burst_master #(
  parameter int         DATA_WIDTH = 64,
  parameter int         ADDR_WIDTH = 32,
  parameter int         STRB_WIDTH = DATA_WIDTH/8,
  parameter logic [3:0] AXI_ID     = 4'h0
) (
  input  logic                  i_aclk,
  input  logic                  i_rst,
  // core request
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_wen,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [7:0]            i_req_len,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  input  logic [STRB_WIDTH-1:0] i_req_wstrb,
  // core response
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_last,
  output logic                  o_rsp_err,
  // AR
  output logic [3:0]            o_arid,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic [7:0]            o_arlen,
  output logic [2:0]            o_arsize,
  output logic [1:0]            o_arburst,
  output logic [1:0]            o_arlock,
  output logic [3:0]            o_arcache,
  output logic [2:0]            o_arprot,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  // R
  input  logic [3:0]            i_rid,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rlast,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  // AW
  output logic [3:0]            o_awid,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic [7:0]            o_awlen,
  output logic [2:0]            o_awsize,
  output logic [1:0]            o_awburst,
  output logic [1:0]            o_awlock,
  output logic [3:0]            o_awcache,
  output logic [2:0]            o_awprot,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  // W
  output logic [3:0]            o_wid,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [STRB_WIDTH-1:0] o_wstrb,
  output logic                  o_wlast,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  // B
  input  logic [3:0]            i_bid,
  input  logic [1:0]            i_bresp,
  input  logic                  i_bvalid,
  output logic                  o_bready
);

  typedef enum logic [2:0] {IDLE, AR, R, WR, B} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  aw_done, w_done;

  logic req_fire, r_fire, aw_fire, w_fire;
  logic beat_last;

  // IDs are not checked; fold them into a sink so they are still consumed.
  logic unused_ids;
  assign unused_ids = ^{i_rid, i_bid};

  assign o_req_ready = (state == IDLE) & ~i_rst;
  assign req_fire    = i_req_valid & o_req_ready;
  assign r_fire      = o_rready & i_rvalid;
  assign aw_fire     = o_awvalid & i_awready;
  assign w_fire      = o_wvalid & i_wready;
  // Burst end is decided by our own beat count, never by the slave's rlast.
  assign beat_last   = (cnt_q == len_q);

  // Constant and latched AXI payloads: all come from registers.
  assign o_arid    = AXI_ID;
  assign o_araddr  = addr_q;
  assign o_arlen   = len_q;
  assign o_arsize  = 3'b011;
  assign o_arburst = 2'b01;
  assign o_arlock  = 2'b00;
  assign o_arcache = 4'h0;
  assign o_arprot  = 3'b000;

  assign o_awid    = AXI_ID;
  assign o_awaddr  = addr_q;
  assign o_awlen   = 8'd0;
  assign o_awsize  = 3'b011;
  assign o_awburst = 2'b01;
  assign o_awlock  = 2'b00;
  assign o_awcache = 4'h0;
  assign o_awprot  = 3'b000;

  assign o_wid     = AXI_ID;
  assign o_wdata   = wdata_q;
  assign o_wstrb   = wstrb_q;
  assign o_wlast   = o_wvalid;

  // State register.
  always_ff @(posedge i_aclk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request latch, beat counter and per-channel done flags for the write.
  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (req_fire) begin
      addr_q  <= i_req_addr;
      len_q   <= i_req_wen ? 8'd0 : i_req_len;
      cnt_q   <= '0;
      wdata_q <= i_req_wdata;
      wstrb_q <= i_req_wstrb;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (r_fire)  cnt_q   <= cnt_q + 8'd1;
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
    end
  end

  // Next state and channel/response outputs; everything defaults to idle.
  always_comb begin
    state_nxt   = state;
    o_arvalid   = 1'b0;
    o_rready    = 1'b0;
    o_awvalid   = 1'b0;
    o_wvalid    = 1'b0;
    o_bready    = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_data  = '0;
    o_rsp_last  = 1'b0;
    o_rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        if (i_req_valid & ~i_rst) state_nxt = i_req_wen ? WR : AR;
      end
      AR: begin
        o_arvalid = 1'b1;
        if (i_arready) state_nxt = R;
      end
      R: begin
        // Zero-latency pass-through; core back-pressure drives rready.
        o_rready    = i_rsp_ready;
        o_rsp_valid = i_rvalid;
        o_rsp_data  = i_rdata;
        o_rsp_last  = beat_last;
        o_rsp_err   = (i_rresp != 2'b00) | (i_rlast != beat_last);
        if (i_rvalid & i_rsp_ready & beat_last) state_nxt = IDLE;
      end
      WR: begin
        // AW and W retire independently; both may retire in one cycle.
        o_awvalid = ~aw_done;
        o_wvalid  = ~w_done;
        if ((aw_done | i_awready) & (w_done | i_wready)) state_nxt = B;
      end
      B: begin
        o_bready    = i_rsp_ready;
        o_rsp_valid = i_bvalid;
        o_rsp_last  = 1'b1;
        o_rsp_err   = (i_bresp != 2'b00);
        if (i_bvalid & i_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22050710_axi4_burst_master.sv
// Scoreboard bench: directed requests push expected responses, a monitor
// pops and compares on every response handshake. A small AXI slave model
// with configurable handshake delays and error injection sits behind the DUT.
module tb_ysyx_22050710_axi4_burst_master;

  logic        i_aclk, i_rst;
  logic        i_req_valid, o_req_ready, i_req_wen;
  logic [31:0] i_req_addr;
  logic [7:0]  i_req_len;
  logic [63:0] i_req_wdata;
  logic [7:0]  i_req_wstrb;
  logic        o_rsp_valid, i_rsp_ready, o_rsp_last, o_rsp_err;
  logic [63:0] o_rsp_data;
  logic [3:0]  o_arid, o_arcache, o_awid, o_awcache, o_wid, i_rid, i_bid;
  logic [31:0] o_araddr, o_awaddr;
  logic [7:0]  o_arlen, o_awlen, o_wstrb;
  logic [2:0]  o_arsize, o_arprot, o_awsize, o_awprot;
  logic [1:0]  o_arburst, o_arlock, o_awburst, o_awlock, i_rresp, i_bresp;
  logic        o_arvalid, i_arready, i_rlast, i_rvalid, o_rready;
  logic        o_awvalid, i_awready, o_wlast, o_wvalid, i_wready, i_bvalid, o_bready;
  logic [63:0] i_rdata, o_wdata;

  ysyx_22050710_axi4_burst_master dut (
    .i_aclk(i_aclk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
    .i_req_addr(i_req_addr), .i_req_len(i_req_len), .i_req_wdata(i_req_wdata),
    .i_req_wstrb(i_req_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_rsp_last(o_rsp_last), .o_rsp_err(o_rsp_err),
    .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arlock(o_arlock), .o_arcache(o_arcache), .o_arprot(o_arprot),
    .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .o_rready(o_rready),
    .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
    .o_awburst(o_awburst), .o_awlock(o_awlock), .o_awcache(o_awcache), .o_awprot(o_awprot),
    .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wid(o_wid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast),
    .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  initial begin
    i_aclk = 1'b0;
    forever #5 i_aclk = ~i_aclk;
  end

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic tog_en = 1'b0;
  logic ready_chk = 1'b0;

  function automatic logic [63:0] init_val(input int i);
    if (i == 0) return 64'h1122334455667788;
    return {32'hC0DE0000 + 32'(i), 32'h00001000 + 32'(i)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic l, input logic e);
    rsp_t r;
    r.data = d; r.last = l; r.err = e;
    exp_q.push_back(r);
  endtask

  // ---------------- slave model ----------------
  logic [63:0] mem [0:63];
  logic        sl_rbusy, sl_aw_got, sl_w_got, sl_bvalid;
  logic [5:0]  sl_ridx, sl_awidx;
  logic [7:0]  sl_rlen, sl_rcnt, sl_wcnt, sl_wstrb;
  logic [63:0] sl_wdata;
  int          cfg_awdelay = 0, cfg_wdelay = 0;
  logic        cfg_early_last = 1'b0;
  logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;

  assign i_arready = 1'b1;
  assign i_rvalid  = sl_rbusy;
  assign i_rdata   = mem[sl_ridx + sl_rcnt[5:0]];
  assign i_rlast   = cfg_early_last ? (sl_rcnt == 8'd0) : (sl_rcnt == sl_rlen);
  assign i_rresp   = cfg_rresp;
  assign i_rid     = 4'h0;
  assign i_awready = o_awvalid && (int'(sl_wcnt) >= cfg_awdelay);
  assign i_wready  = o_wvalid && (int'(sl_wcnt) >= cfg_wdelay);
  assign i_bvalid  = sl_bvalid;
  assign i_bresp   = cfg_bresp;
  assign i_bid     = 4'h0;

  // Slave: reset restores memory; write commits once both AW and W arrived.
  always @(posedge i_aclk) begin : slave
    logic        aw_h, w_h;
    logic [5:0]  aidx;
    logic [63:0] wd;
    logic [7:0]  ws;
    if (i_rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      sl_rbusy <= 1'b0; sl_rcnt <= '0; sl_rlen <= '0; sl_ridx <= '0;
      sl_wcnt <= '0; sl_aw_got <= 1'b0; sl_w_got <= 1'b0; sl_bvalid <= 1'b0;
      sl_awidx <= '0; sl_wdata <= '0; sl_wstrb <= '0;
    end else begin
      if (o_arvalid && i_arready) begin
        sl_rbusy <= 1'b1; sl_ridx <= o_araddr[8:3]; sl_rlen <= o_arlen; sl_rcnt <= '0;
      end else if (sl_rbusy && o_rready) begin
        sl_rcnt <= sl_rcnt + 8'd1;
        if (sl_rcnt == sl_rlen) sl_rbusy <= 1'b0;
      end
      sl_wcnt <= (o_awvalid || o_wvalid) ? sl_wcnt + 8'd1 : 8'd0;
      aw_h = sl_aw_got || (o_awvalid && i_awready);
      w_h  = sl_w_got  || (o_wvalid && i_wready);
      aidx = sl_aw_got ? sl_awidx : o_awaddr[8:3];
      wd   = sl_w_got ? sl_wdata : o_wdata;
      ws   = sl_w_got ? sl_wstrb : o_wstrb;
      if (o_awvalid && i_awready) sl_awidx <= o_awaddr[8:3];
      if (o_wvalid && i_wready) begin sl_wdata <= o_wdata; sl_wstrb <= o_wstrb; end
      if (aw_h && w_h) begin
        for (int b = 0; b < 8; b++) if (ws[b]) mem[aidx][8*b +: 8] <= wd[8*b +: 8];
        sl_bvalid <= 1'b1; sl_aw_got <= 1'b0; sl_w_got <= 1'b0;
      end else begin
        sl_aw_got <= aw_h; sl_w_got <= w_h;
      end
      if (sl_bvalid && o_bready) sl_bvalid <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge i_aclk) begin : mon
    rsp_t e;
    if (ready_chk) begin
      chk("req_ready_after_last", {63'd0, o_req_ready}, 64'd1);
      ready_chk = 1'b0;
    end
    if (!i_rst && i_rvalid) chk("rready_mirror", {63'd0, o_rready}, {63'd0, i_rsp_ready});
    if (!i_rst && o_rsp_valid && i_rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_rsp: got data 0x%0h with no response expected", o_rsp_data);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", o_rsp_data, e.data);
        chk("rsp_last", {63'd0, o_rsp_last}, {63'd0, e.last});
        chk("rsp_err",  {63'd0, o_rsp_err},  {63'd0, e.err});
        if (e.last) ready_chk = 1'b1;
      end
    end
  end

  // Optional 1/0 toggling of response back-pressure.
  initial begin
    forever begin
      @(posedge i_aclk); #1;
      if (tog_en) i_rsp_ready = ~i_rsp_ready;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [7:0] len,
                       input logic [63:0] wd, input logic [7:0] ws);
    bit ok;
    ok = 1'b0;
    i_req_valid = 1'b1; i_req_wen = wen; i_req_addr = addr;
    i_req_len = len; i_req_wdata = wd; i_req_wstrb = ws;
    for (int k = 0; k < 200; k++) begin
      @(negedge i_aclk);
      if (o_req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout: got o_req_ready 0, expected 1 within 200 cycles");
    end
    @(posedge i_aclk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge i_aclk);
      k++;
    end
    chk("rsp_drain_outstanding", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  logic [63:0] tmp;

  initial begin
    i_rst = 1'b1; i_req_valid = 1'b0; i_req_wen = 1'b0; i_req_addr = '0;
    i_req_len = '0; i_req_wdata = '0; i_req_wstrb = '0; i_rsp_ready = 1'b1;

    // reset
    repeat (3) begin
      @(negedge i_aclk);
      chk("rst_req_ready", {63'd0, o_req_ready}, 64'd0);
      chk("rst_valids", {59'd0, o_arvalid, o_awvalid, o_wvalid, o_rsp_valid, o_rready}, 64'd0);
      chk("rst_bready", {63'd0, o_bready}, 64'd0);
    end
    @(posedge i_aclk); #1;
    i_rst = 1'b0;
    @(negedge i_aclk);
    chk("req_ready_after_rst", {63'd0, o_req_ready}, 64'd1);
    chk("idle_rsp_data", o_rsp_data, 64'd0);
    @(posedge i_aclk); #1;

    // single read
    push(64'h1122334455667788, 1'b1, 1'b0);
    issue(1'b0, 32'h8000_0000, 8'd0, 64'd0, 8'd0);
    @(negedge i_aclk);
    chk("single_arvalid", {63'd0, o_arvalid}, 64'd1);
    chk("single_arlen", {56'd0, o_arlen}, 64'd0);
    chk("single_araddr", {32'd0, o_araddr}, 64'h8000_0000);
    chk("single_arsize_burst", {59'd0, o_arsize, o_arburst}, {59'd0, 3'b011, 2'b01});
    wait_done(50);
    @(posedge i_aclk); #1;

    // burst read with toggling back-pressure
    for (int k = 0; k < 4; k++) push(init_val(32 + k), k == 3, 1'b0);
    tog_en = 1'b1;
    issue(1'b0, 32'h8000_0100, 8'd3, 64'd0, 8'd0);
    @(negedge i_aclk);
    chk("burst_arlen", {56'd0, o_arlen}, 64'd3);
    wait_done(100);
    tog_en = 1'b0;
    @(posedge i_aclk); #1;
    i_rsp_ready = 1'b1;

    // write: W accepted two cycles before AW
    cfg_wdelay = 1; cfg_awdelay = 3;
    push(64'd0, 1'b1, 1'b0);
    issue(1'b1, 32'h8000_0008, 8'hFF, 64'h0000_0000_DEAD_BEEF, 8'h0F);
    @(negedge i_aclk);
    chk("wr_both_valid", {62'd0, o_awvalid, o_wvalid}, 64'd3);
    chk("wr_awlen_forced0", {56'd0, o_awlen}, 64'd0);
    chk("wr_wlast", {63'd0, o_wlast}, 64'd1);
    @(negedge i_aclk);
    @(negedge i_aclk);
    chk("wr_w_dropped_aw_held", {62'd0, o_awvalid, o_wvalid}, 64'd2);
    chk("wr_awaddr_stable", {32'd0, o_awaddr}, 64'h8000_0008);
    wait_done(50);
    tmp = init_val(1);
    chk("wr_mem_bytes", mem[1], {tmp[63:32], 32'hDEAD_BEEF});
    @(posedge i_aclk); #1;
    cfg_wdelay = 0; cfg_awdelay = 0;

    // read back through the DUT
    push({tmp[63:32], 32'hDEAD_BEEF}, 1'b1, 1'b0);
    issue(1'b0, 32'h8000_0008, 8'd0, 64'd0, 8'd0);
    wait_done(50);
    @(posedge i_aclk); #1;

    // slave asserts rlast on beat 0 of a 2-beat burst
    cfg_early_last = 1'b1;
    push(init_val(8), 1'b0, 1'b1);
    push(init_val(9), 1'b1, 1'b1);
    issue(1'b0, 32'h8000_0040, 8'd1, 64'd0, 8'd0);
    wait_done(50);
    @(posedge i_aclk); #1;
    cfg_early_last = 1'b0;

    // SLVERR on a read
    cfg_rresp = 2'b10;
    push(init_val(2), 1'b1, 1'b1);
    issue(1'b0, 32'h8000_0010, 8'd0, 64'd0, 8'd0);
    wait_done(50);
    @(posedge i_aclk); #1;
    cfg_rresp = 2'b00;

    // DECERR on a write, AW and W accepted in the same cycle
    cfg_bresp = 2'b11;
    push(64'd0, 1'b1, 1'b1);
    issue(1'b1, 32'h8000_0018, 8'd0, 64'h0123_4567_89AB_CDEF, 8'hFF);
    wait_done(50);
    @(posedge i_aclk); #1;
    cfg_bresp = 2'b00;

    // reset after beat 1 of an 8-beat burst
    i_rsp_ready = 1'b0;
    push(init_val(16), 1'b0, 1'b0);
    push(init_val(17), 1'b0, 1'b0);
    issue(1'b0, 32'h8000_0080, 8'd7, 64'd0, 8'd0);
    repeat (2) @(posedge i_aclk);
    #1;
    i_rsp_ready = 1'b1;
    repeat (2) @(posedge i_aclk);
    #1;
    i_rsp_ready = 1'b0;
    i_rst = 1'b1;
    chk("midrst_beats_seen", 64'(exp_q.size()), 64'd0);
    @(posedge i_aclk); #1;
    @(negedge i_aclk);
    chk("midrst_valids", {59'd0, o_arvalid, o_awvalid, o_wvalid, o_rsp_valid, o_rready}, 64'd0);
    chk("midrst_slave_quiet", {62'd0, i_rvalid, o_bready}, 64'd0);
    @(posedge i_aclk); #1;
    i_rst = 1'b0;
    i_rsp_ready = 1'b1;
    @(negedge i_aclk);
    chk("midrst_idle", {63'd0, o_req_ready}, 64'd1);
    @(posedge i_aclk); #1;
    push(init_val(5), 1'b1, 1'b0);
    issue(1'b0, 32'h8000_0028, 8'd0, 64'd0, 8'd0);
    wait_done(50);
    repeat (2) @(posedge i_aclk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
